// File: rtl/misao_alu_serial_if.sv
// Request/result bundle between the control FSM, the serial ALU and the register file.
interface misao_alu_serial_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [1:0]        mode;
    logic              carry_en;
    logic [DATA_W-1:0] acc_in;
    logic [DATA_W-1:0] rs_in;
    logic              carry_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] acc_out;
    logic              carry_out;
    logic              zero_out;

    modport master (
        output in_valid, op, mode, carry_en, acc_in, rs_in, carry_in, out_ready,
        input  in_ready, out_valid, acc_out, carry_out, zero_out
    );

    modport slave (
        input  in_valid, op, mode, carry_en, acc_in, rs_in, carry_in, out_ready,
        output in_ready, out_valid, acc_out, carry_out, zero_out
    );
endinterface

// File: rtl/misao_alu_serial.sv
// Digit-serial ALU: one accumulator/RS0 operation over a 4/8/16/DATA_W-bit window,
// DIGIT_W bits per cycle, carry/borrow rippling through an internal carry register.
module misao_alu_serial #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DIGIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    misao_alu_serial_if.slave   bus
);
    localparam int unsigned PW = $clog2(DATA_W);
    localparam int unsigned CW = $clog2(DATA_W + 1);
    localparam int unsigned SW = DIGIT_W + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_INV = 4'd5;
    localparam logic [3:0] OP_INC = 4'd6;
    localparam logic [3:0] OP_DEC = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;
    logic   capture, step, commit;

    logic [3:0]        op_q;
    logic              carry_en_q;
    logic              carry_in_q;
    logic [DATA_W-1:0] a_q, b_q, r_q, mask_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     pos_q;
    logic              first_q;
    logic              c_q;

    logic [CW-1:0]      width_c;
    logic [DIGIT_W-1:0] a_d, b_d, d_res;
    logic [SW-1:0]      sum;
    logic               cc, c_nxt, uses_c;

    // Active window width selected by mode
    always_comb begin
        case (bus.mode)
            2'd0:    width_c = CW'(4);
            2'd1:    width_c = CW'(8);
            2'd2:    width_c = CW'(16);
            default: width_c = CW'(DATA_W);
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; RUN spends one extra cycle (cnt_q == 0) committing the result
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)     state_nxt = RUN;
            RUN:     if (cnt_q == '0)      state_nxt = DONE;
            DONE:    if (bus.out_ready)    state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Datapath strobes decoded from state
    always_comb begin
        capture = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE:    capture = bus.in_valid;
            RUN: begin
                step   = (cnt_q != '0);
                commit = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    // One digit of the selected operation; carry/borrow injection happens on the first digit
    always_comb begin
        a_d    = a_q[pos_q +: DIGIT_W];
        b_d    = b_q[pos_q +: DIGIT_W];
        sum    = '0;
        d_res  = a_d;
        c_nxt  = c_q;
        uses_c = 1'b0;
        cc     = c_q;
        if (first_q) begin
            case (op_q)
                OP_ADD, OP_SUB: cc = carry_en_q & carry_in_q;
                OP_INC, OP_DEC: cc = 1'b1;
                default:        cc = 1'b0;
            endcase
        end
        case (op_q)
            OP_ADD: begin
                sum = {1'b0, a_d} + {1'b0, b_d} + SW'(cc);
                d_res = sum[DIGIT_W-1:0]; c_nxt = sum[DIGIT_W]; uses_c = 1'b1;
            end
            OP_SUB: begin
                sum = {1'b0, a_d} - {1'b0, b_d} - SW'(cc);
                d_res = sum[DIGIT_W-1:0]; c_nxt = sum[DIGIT_W]; uses_c = 1'b1;
            end
            OP_INC: begin
                sum = {1'b0, a_d} + SW'(cc);
                d_res = sum[DIGIT_W-1:0]; c_nxt = sum[DIGIT_W]; uses_c = 1'b1;
            end
            OP_DEC: begin
                sum = {1'b0, a_d} - SW'(cc);
                d_res = sum[DIGIT_W-1:0]; c_nxt = sum[DIGIT_W]; uses_c = 1'b1;
            end
            OP_SHL: begin
                sum = {a_d, c_q};
                d_res = sum[DIGIT_W-1:0]; c_nxt = sum[DIGIT_W]; uses_c = 1'b1;
            end
            OP_SHR: begin
                sum = {c_q, a_d};
                d_res = sum[DIGIT_W:1]; c_nxt = sum[0]; uses_c = 1'b1;
            end
            OP_AND:  d_res = a_d & b_d;
            OP_OR:   d_res = a_d | b_d;
            OP_XOR:  d_res = a_d ^ b_d;
            OP_INV:  d_res = ~a_d;
            default: d_res = a_d;
        endcase
    end

    // Operand capture and digit stepping; r_q starts as acc_in so bits above the window pass through
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= '0;
            carry_en_q <= 1'b0;
            carry_in_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            pos_q      <= '0;
            first_q    <= 1'b0;
            c_q        <= 1'b0;
        end else if (capture) begin
            op_q       <= bus.op;
            carry_en_q <= bus.carry_en;
            carry_in_q <= bus.carry_in;
            a_q        <= bus.acc_in;
            b_q        <= bus.rs_in;
            r_q        <= bus.acc_in;
            mask_q     <= DATA_W'({DATA_W{1'b1}} >> (CW'(DATA_W) - width_c));
            cnt_q      <= CW'(width_c / CW'(DIGIT_W));
            pos_q      <= (bus.op == OP_SHR) ? PW'(width_c - CW'(DIGIT_W)) : '0;
            first_q    <= 1'b1;
            c_q        <= 1'b0;
        end else if (step) begin
            r_q[pos_q +: DIGIT_W] <= d_res;
            c_q     <= c_nxt;
            first_q <= 1'b0;
            cnt_q   <= cnt_q - CW'(1);
            pos_q   <= (op_q == OP_SHR) ? pos_q - PW'(DIGIT_W) : pos_q + PW'(DIGIT_W);
        end
    end

    // Registered handshake and result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.acc_out   <= '0;
            bus.carry_out <= 1'b0;
            bus.zero_out  <= 1'b1;
        end else begin
            bus.in_ready  <= (state_nxt == IDLE);
            bus.out_valid <= (state_nxt == DONE);
            if (commit) begin
                bus.acc_out   <= r_q;
                bus.carry_out <= uses_c ? c_q : carry_in_q;
                bus.zero_out  <= ((r_q & mask_q) == '0);
            end
        end
    end
endmodule

// File: tb/tb_misao_alu_serial.sv
// Directed bench for misao_alu_serial: a 16-bit/4-bit-digit instance and a 32-bit/1-bit-digit instance.
module tb_misao_alu_serial;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    misao_alu_serial_if #(.DATA_W(16)) bus0 ();
    misao_alu_serial_if #(.DATA_W(32)) bus1 ();

    misao_alu_serial #(.DATA_W(16), .DIGIT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    misao_alu_serial #(.DATA_W(32), .DIGIT_W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                           INV = 4'd5, INC = 4'd6, DEC = 4'd7, SHL = 4'd8, SHR = 4'd9, NOP = 4'd12;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs_acc(input bit sel);
        return sel ? bus1.acc_out : {16'h0, bus0.acc_out};
    endfunction
    function automatic logic obs_c(input bit sel);   return sel ? bus1.carry_out : bus0.carry_out; endfunction
    function automatic logic obs_z(input bit sel);   return sel ? bus1.zero_out  : bus0.zero_out;  endfunction
    function automatic logic obs_v(input bit sel);   return sel ? bus1.out_valid : bus0.out_valid; endfunction
    function automatic logic obs_rdy(input bit sel); return sel ? bus1.in_ready  : bus0.in_ready;  endfunction

    task automatic drive(input bit sel, input logic v, input logic [3:0] op, input logic [1:0] mode,
                         input logic cen, input logic [31:0] a, input logic [31:0] b, input logic cin);
        if (sel) begin
            bus1.in_valid = v; bus1.op = op; bus1.mode = mode; bus1.carry_en = cen;
            bus1.acc_in = a; bus1.rs_in = b; bus1.carry_in = cin;
        end else begin
            bus0.in_valid = v; bus0.op = op; bus0.mode = mode; bus0.carry_en = cen;
            bus0.acc_in = a[15:0]; bus0.rs_in = b[15:0]; bus0.carry_in = cin;
        end
    endtask

    // Issue one request; operands are scrambled right after acceptance to prove capture
    task automatic start_op(input bit sel, input string tag, input logic [3:0] op, input logic [1:0] mode,
                            input logic cen, input logic [31:0] a, input logic [31:0] b, input logic cin);
        int n;
        n = 0;
        while (!obs_rdy(sel) && n < 200) begin @(posedge clk); #1; n++; end
        check({tag, "_rdy"}, 32'(obs_rdy(sel)), 32'd1);
        drive(sel, 1'b1, op, mode, cen, a, b, cin);
        @(posedge clk); #1;
        drive(sel, 1'b0, ~op, ~mode, ~cen, ~a, ~b, ~cin);
    endtask

    task automatic wait_valid(input bit sel, output int lat);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!obs_v(sel) && lat < 100);
    endtask

    task automatic run_op(input bit sel, input string tag, input logic [3:0] op, input logic [1:0] mode,
                          input logic cen, input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic [31:0] exp_acc, input logic exp_c, input logic exp_z, input int exp_lat);
        int lat;
        start_op(sel, tag, op, mode, cen, a, b, cin);
        wait_valid(sel, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_acc"}, obs_acc(sel), exp_acc);
        check({tag, "_c"},   32'(obs_c(sel)), 32'(exp_c));
        check({tag, "_z"},   32'(obs_z(sel)), 32'(exp_z));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        rst = 1'b0;
        drive(1'b0, 1'b0, NOP, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, NOP, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_rdy", 32'(obs_rdy(s[0])), 32'd1);
            check("rst_v",   32'(obs_v(s[0])),   32'd0);
            check("rst_acc", obs_acc(s[0]),      32'h0);
            check("rst_c",   32'(obs_c(s[0])),   32'd0);
            check("rst_z",   32'(obs_z(s[0])),   32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        // 4-bit add/sub chain
        run_op(0, "add3", ADD, 2'd0, 1'b1, 32'h0003, 32'h0005, 1'b0, 32'h0008, 1'b0, 1'b0, 2);
        run_op(0, "add8", ADD, 2'd0, 1'b1, 32'h0008, 32'h0005, 1'b0, 32'h000D, 1'b0, 1'b0, 2);
        run_op(0, "addD", ADD, 2'd0, 1'b1, 32'h000D, 32'h0005, 1'b0, 32'h0002, 1'b1, 1'b0, 2);
        run_op(0, "sub35", SUB, 2'd0, 1'b1, 32'h0003, 32'h0005, 1'b0, 32'h000E, 1'b1, 1'b0, 2);

        // 4-bit logic and shifts, upper bits pass through
        run_op(0, "and", AND_, 2'd0, 1'b0, 32'hABCA, 32'h000C, 1'b1, 32'hABC8, 1'b1, 1'b0, 2);
        run_op(0, "or",  OR_,  2'd0, 1'b0, 32'hABCA, 32'h000C, 1'b0, 32'hABCE, 1'b0, 1'b0, 2);
        run_op(0, "xor", XOR_, 2'd0, 1'b0, 32'hABCC, 32'h000C, 1'b1, 32'hABC0, 1'b1, 1'b1, 2);
        run_op(0, "inv", INV,  2'd0, 1'b0, 32'hABC0, 32'h0000, 1'b0, 32'hABCF, 1'b0, 1'b0, 2);
        run_op(0, "shl", SHL,  2'd0, 1'b0, 32'hABCF, 32'h0000, 1'b0, 32'hABCE, 1'b1, 1'b0, 2);
        run_op(0, "shr", SHR,  2'd0, 1'b0, 32'hABCE, 32'h0000, 1'b1, 32'hABC7, 1'b0, 1'b0, 2);
        run_op(0, "nop", NOP,  2'd0, 1'b0, 32'h1234, 32'h5555, 1'b1, 32'h1234, 1'b1, 1'b0, 2);

        // Wider windows
        run_op(0, "add8w",  ADD, 2'd1, 1'b0, 32'h00FF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b1, 3);
        run_op(0, "add16w", ADD, 2'd2, 1'b0, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b1, 5);
        run_op(0, "cin_on", ADD, 2'd2, 1'b1, 32'h00FF, 32'h0000, 1'b1, 32'h0100, 1'b0, 1'b0, 5);
        run_op(0, "cin_off",ADD, 2'd2, 1'b0, 32'h00FF, 32'h0000, 1'b1, 32'h00FF, 1'b0, 1'b0, 5);
        run_op(0, "dec0",   DEC, 2'd2, 1'b1, 32'h0000, 32'h0000, 1'b1, 32'hFFFF, 1'b1, 1'b0, 5);
        run_op(0, "incF",   INC, 2'd3, 1'b1, 32'hFFFF, 32'h0000, 1'b1, 32'h0000, 1'b1, 1'b1, 5);
        run_op(0, "sub16",  SUB, 2'd2, 1'b1, 32'h1000, 32'h0001, 1'b1, 32'h0FFE, 1'b0, 1'b0, 5);
        run_op(0, "shl8",   SHL, 2'd1, 1'b0, 32'h5681, 32'h0000, 1'b0, 32'h5602, 1'b1, 1'b0, 3);
        run_op(0, "shr16",  SHR, 2'd2, 1'b0, 32'h8001, 32'h0000, 1'b0, 32'h4000, 1'b1, 1'b0, 5);

        // DONE held with out_ready low; new requests must be ignored
        bus0.out_ready = 1'b0;
        start_op(0, "hold", ADD, 2'd0, 1'b0, 32'h0001, 32'h0001, 1'b0);
        wait_valid(0, lat);
        check("hold_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 7; i++) begin
            drive(0, 1'b1, ADD, 2'd0, 1'b0, 32'h0007, 32'h0007, 1'b0);
            @(posedge clk); #1;
            check("hold_v",   32'(bus0.out_valid), 32'd1);
            check("hold_acc", obs_acc(0), 32'h0002);
            check("hold_rdy", 32'(bus0.in_ready), 32'd0);
        end
        drive(0, 1'b0, ADD, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        check("rel_rdy", 32'(bus0.in_ready), 32'd1);
        check("rel_v",   32'(bus0.out_valid), 32'd0);
        run_op(0, "after", ADD, 2'd0, 1'b0, 32'h0004, 32'h0002, 1'b0, 32'h0006, 1'b0, 1'b0, 2);

        // Bit-serial instance
        run_op(1, "w1_add16", ADD, 2'd2, 1'b0, 32'h00001234, 32'h00001111, 1'b0, 32'h00002345, 1'b0, 1'b0, 17);
        run_op(1, "w1_add4",  ADD, 2'd0, 1'b0, 32'hABCDEF0F, 32'h00000001, 1'b0, 32'hABCDEF00, 1'b1, 1'b1, 5);
        run_op(1, "w1_add16b",ADD, 2'd2, 1'b0, 32'h00001234, 32'h00001111, 1'b0, 32'h00002345, 1'b0, 1'b0, 17);

        // Asynchronous reset in the middle of a 32-bit run
        start_op(1, "abort", ADD, 2'd3, 1'b0, 32'h12345678, 32'h11111111, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_v",   32'(bus1.out_valid), 32'd0);
        check("abort_acc", obs_acc(1), 32'h0);
        check("abort_rdy", 32'(bus1.in_ready), 32'd1);
        check("abort_z",   32'(bus1.zero_out), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(1, "w1_full", ADD, 2'd3, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 33);
        run_op(1, "w1_sub",  SUB, 2'd3, 1'b1, 32'h12345678, 32'h11111111, 1'b1, 32'h01234566, 1'b0, 1'b0, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
